vga_fb_port_ctrl: RTL and testbench
===================================

Name: vga_fb_port_ctrl

Overview:
- Owns frame buffer port A (write/read side) and shares it between two requesters.
- Requester 1 is processor single-pixel access. Requester 2 is an internal rectangle-fill engine used for screen clear and box draw.
- Also holds the CONFIG_COLOURS register that feeds the VGA signal generator.
- Sits between the processor bus decode and the VGA top wrapper.

Parameters:
H_PIXELS, 160, visible columns; X coordinates 0..H_PIXELS-1
V_PIXELS, 120, visible rows; Y coordinates 0..V_PIXELS-1
COLOUR_RESET, 16'h00FF, reset value of CONFIG_COLOURS

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
CPU_REQ  in  1  one-cycle access strobe; each high cycle is one access
CPU_WE  in  1  1 = write, 0 = read
CPU_X  in  8  pixel column
CPU_Y  in  7  pixel row
CPU_WDATA  in  1  pixel value to write
CPU_ACK  out  1  pulse: access issued
CPU_RDATA  out  1  read pixel value, held until next read completes
CPU_RVALID  out  1  pulse: CPU_RDATA updated
FILL_START  in  1  start rectangle fill
FILL_X0, FILL_X1  in  8  inclusive column bounds
FILL_Y0, FILL_Y1  in  7  inclusive row bounds
FILL_VALUE  in  1  pixel value written by the fill
FILL_BUSY  out  1  fill in progress
FILL_DONE  out  1  pulse: fill finished
COLOUR_WE  in  1  load CONFIG_COLOURS
COLOUR_IN  in  16  new colour pair
CONFIG_COLOURS  out  16  to VGA signal generator
FB_ADDR  out  15  to frame buffer A_ADDR; address = {Y[6:0], X[7:0]}
FB_WDATA  out  1  to frame buffer A_DATA_IN
FB_WE  out  1  to frame buffer A_WE
FB_RDATA  in  1  from frame buffer A_DATA_OUT; valid one cycle after address is presented

Behaviour:
- Clock and reset:
  - Single clock domain. All outputs are registered.
- Reset values:
  - FB_ADDR=0, FB_WDATA=0, FB_WE=0.
  - CPU_ACK=0, CPU_RDATA=0, CPU_RVALID=0.
  - FILL_BUSY=0, FILL_DONE=0.
  - CONFIG_COLOURS=COLOUR_RESET.
  - FSM=IDLE.
- Arbitration:
  - Fixed priority; CPU always wins the port.
  - The fill engine uses only cycles with CPU_REQ=0. Its counters hold while preempted.
  - Continuous CPU_REQ may starve the fill; this is accepted behaviour.
- CPU access:
  - CPU_REQ sampled high in cycle n → FB_ADDR/FB_WE/FB_WDATA driven in cycle n+1, CPU_ACK=1 in cycle n+1.
  - Reads: FB_RDATA is captured at the end of cycle n+2. CPU_RDATA updates and CPU_RVALID=1 in cycle n+3.
  - Back-to-back reads pipeline: one result per cycle.
- Out-of-range CPU access (X≥H_PIXELS or Y≥V_PIXELS):
  - CPU_ACK still pulses and FB_WE stays 0.
  - A read returns CPU_RDATA=0 with the normal CPU_RVALID timing.
- Fill FSM states IDLE, FILL, DONE:
  - IDLE: on FILL_START, latch clamped bounds and FILL_VALUE.
    - X1c=min(FILL_X1,H_PIXELS-1); Y1c=min(FILL_Y1,V_PIXELS-1).
    - Load x=FILL_X0, y=FILL_Y0.
    - Empty region (X0>X1c or Y0>Y1c): go to DONE with no writes.
    - Otherwise go to FILL. FILL_BUSY=1 from the following cycle.
  - FILL: each non-preempted cycle drives one write at {y,x} with FB_WE=1 in the next cycle.
    - Order is raster: x increments; at x=X1c, x←X0 and y increments.
    - After issuing {Y1c,X1c}, go to DONE.
  - DONE: one cycle. FILL_DONE=1 and FILL_BUSY=0 in the cycle after the last fill FB_WE; then IDLE.
- Simultaneous and ignored events:
  - FILL_START while FILL_BUSY or in DONE is ignored.
  - FILL_START and CPU_REQ in the same cycle: both are accepted; the CPU access is issued first.
- Colour register:
  - COLOUR_WE loads COLOUR_IN; CONFIG_COLOURS updates in the next cycle, independent of arbitration.
- Reset mid-operation:
  - Aborts the fill immediately. No FILL_DONE is generated.
  - In-flight CPU_RVALID is dropped.
  - The frame buffer contents are not cleared.

Test Plan:
- Reset: assert RESET 2 cycles → all outputs at reset values; CONFIG_COLOURS=16'h00FF; 20 idle cycles show FB_WE=0.
- CPU write then read: write X=5,Y=3,data=1 in cycle n → FB_ADDR=15'h0305, FB_WE=1, CPU_ACK=1 in n+1. Read of the same pixel in n+2 → CPU_RVALID=1, CPU_RDATA=1 in n+5.
- Fill X0=0,X1=3,Y0=0,Y1=1,value=1 → 8 consecutive FB_WE cycles at addresses 0,1,2,3,256,257,258,259; FILL_DONE pulses once, the cycle after address 259.
- CPU preemption: CPU_REQ for 2 cycles mid-fill → those 2 cycles carry CPU addresses; the fill resumes at the next raster address, no pixel skipped or duplicated, and completion is delayed by 2 cycles.
- Clipping and empty fill:
  - X0=158,X1=200,Y0=119,Y1=127 → writes only at 15'h779E and 15'h779F.
  - X0=10,X1=5 → FILL_DONE with zero writes.
  - CPU write at X=160 → CPU_ACK=1, FB_WE=0.
- Reset mid-fill plus colour load:
  - RESET during a 160×120 clear → FB_WE=0 and FILL_BUSY=0 the cycle after; no FILL_DONE.
  - COLOUR_WE with 16'hE01C → CONFIG_COLOURS=16'hE01C the next cycle.

Source files
------------

// File: rtl/vga_fb_port_ctrl.sv
// Frame buffer port A controller: arbitrates processor pixel access (fixed priority)
// against a raster rectangle-fill engine, and holds the CONFIG_COLOURS register.
module vga_fb_port_ctrl #(
  parameter int          H_PIXELS     = 160,
  parameter int          V_PIXELS     = 120,
  parameter logic [15:0] COLOUR_RESET = 16'h00FF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cpuReq_i,
  input  logic        cpuWe_i,
  input  logic [7:0]  cpuX_i,
  input  logic [6:0]  cpuY_i,
  input  logic        cpuWdata_i,
  output logic        cpuAck_o,
  output logic        cpuRdata_o,
  output logic        cpuRvalid_o,
  input  logic        fillStart_i,
  input  logic [7:0]  fillX0_i,
  input  logic [7:0]  fillX1_i,
  input  logic [6:0]  fillY0_i,
  input  logic [6:0]  fillY1_i,
  input  logic        fillValue_i,
  output logic        fillBusy_o,
  output logic        fillDone_o,
  input  logic        colourWe_i,
  input  logic [15:0] colourIn_i,
  output logic [15:0] configColours_o,
  output logic [14:0] fbAddr_o,
  output logic        fbWdata_o,
  output logic        fbWe_o,
  input  logic        fbRdata_i
);

  localparam logic [7:0] X_LAST = 8'(H_PIXELS - 1);
  localparam logic [6:0] Y_LAST = 7'(V_PIXELS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [7:0]  x0_q, x0_d;
  logic [7:0]  x1_q, x1_d;
  logic [6:0]  y1_q, y1_d;
  logic        value_q, value_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [14:0] fbAddr_q, fbAddr_d;
  logic        fbWdata_q, fbWdata_d;
  logic        fbWe_q, fbWe_d;
  logic        ack_q, ack_d;

  logic        rdPend1_q, rdPend1_d;
  logic        rdOk1_q, rdOk1_d;
  logic        rdPend2_q;
  logic        rdOk2_q;
  logic        rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  logic [15:0] colours_q, colours_d;

  logic [7:0]  x1Clamp;
  logic [6:0]  y1Clamp;
  logic        fillEmpty;
  logic        cpuInRange;
  logic        fillGo;
  logic        fillLast;

  always_comb begin
    x1Clamp    = (fillX1_i > X_LAST) ? X_LAST : fillX1_i;
    y1Clamp    = (fillY1_i > Y_LAST) ? Y_LAST : fillY1_i;
    fillEmpty  = (fillX0_i > x1Clamp) || (fillY0_i > y1Clamp);
    cpuInRange = (cpuX_i <= X_LAST) && (cpuY_i <= Y_LAST);
    fillGo     = (state_q == ST_FILL) && !cpuReq_i;
    fillLast   = (x_q == x1_q) && (y_q == y1_q);
  end

  // Fill engine: raster walk over the clamped rectangle, stalling whenever the CPU owns the port.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    value_d = value_q;
    case (state_q)
      ST_IDLE: begin
        if (fillStart_i) begin
          x0_d    = fillX0_i;
          x1_d    = x1Clamp;
          y1_d    = y1Clamp;
          x_d     = fillX0_i;
          y_d     = fillY0_i;
          value_d = fillValue_i;
          state_d = fillEmpty ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (fillGo) begin
          if (fillLast) begin
            state_d = ST_DONE;
          end else if (x_q == x1_q) begin
            x_d = x0_q;
            y_d = y_q + 7'd1;
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Busy covers the FILL cycles plus the cycle carrying the last write, never an empty fill.
    busy_d = (state_d == ST_FILL) || (state_q == ST_FILL);
    done_d = (state_q == ST_DONE);
  end

  // Port A mux: CPU always wins; the address and data lines hold when nobody drives a write.
  always_comb begin
    fbAddr_d  = fbAddr_q;
    fbWdata_d = fbWdata_q;
    fbWe_d    = 1'b0;
    ack_d     = cpuReq_i;
    rdPend1_d = cpuReq_i && !cpuWe_i;
    rdOk1_d   = cpuInRange;
    if (cpuReq_i) begin
      fbAddr_d  = {cpuY_i, cpuX_i};
      fbWdata_d = cpuWdata_i;
      fbWe_d    = cpuWe_i && cpuInRange;
    end else if (fillGo) begin
      fbAddr_d  = {y_q, x_q};
      fbWdata_d = value_q;
      fbWe_d    = 1'b1;
    end
  end

  // Read return: frame buffer data is valid the cycle after the address, out-of-range reads yield 0.
  always_comb begin
    rvalid_d  = rdPend2_q;
    rdata_d   = rdPend2_q ? (rdOk2_q & fbRdata_i) : rdata_q;
    colours_d = colourWe_i ? colourIn_i : colours_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      value_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fbAddr_q  <= '0;
      fbWdata_q <= 1'b0;
      fbWe_q    <= 1'b0;
      ack_q     <= 1'b0;
      rdPend1_q <= 1'b0;
      rdOk1_q   <= 1'b0;
      rdPend2_q <= 1'b0;
      rdOk2_q   <= 1'b0;
      rdata_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      colours_q <= COLOUR_RESET;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      value_q   <= value_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fbAddr_q  <= fbAddr_d;
      fbWdata_q <= fbWdata_d;
      fbWe_q    <= fbWe_d;
      ack_q     <= ack_d;
      rdPend1_q <= rdPend1_d;
      rdOk1_q   <= rdOk1_d;
      rdPend2_q <= rdPend1_q;
      rdOk2_q   <= rdOk1_q;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      colours_q <= colours_d;
    end
  end

  assign cpuAck_o        = ack_q;
  assign cpuRdata_o      = rdata_q;
  assign cpuRvalid_o     = rvalid_q;
  assign fillBusy_o      = busy_q;
  assign fillDone_o      = done_q;
  assign configColours_o = colours_q;
  assign fbAddr_o        = fbAddr_q;
  assign fbWdata_o       = fbWdata_q;
  assign fbWe_o          = fbWe_q;

endmodule

// File: tb/tb_vga_fb_port_ctrl.sv
// Directed bench for vga_fb_port_ctrl with a one-cycle-latency frame buffer model on port A.
module tb_vga_fb_port_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpuReq, cpuWe, cpuWdata;
  logic [7:0]  cpuX;
  logic [6:0]  cpuY;
  logic        cpuAck, cpuRdata, cpuRvalid;
  logic        fillStart, fillValue;
  logic [7:0]  fillX0, fillX1;
  logic [6:0]  fillY0, fillY1;
  logic        fillBusy, fillDone;
  logic        colourWe;
  logic [15:0] colourIn, configColours;
  logic [14:0] fbAddr;
  logic        fbWdata, fbWe;
  logic        fbRdata = 1'b0;

  logic        fbMem [0:32767];
  logic        pokeEn = 1'b0;
  logic [14:0] pokeAddr = '0;

  int nChecks = 0;
  int nFails  = 0;

  logic [14:0] wrAddr[$];
  int          wrCycle[$];
  int          doneCycles[$];
  logic        sawBusy;

  vga_fb_port_ctrl #(.H_PIXELS(160), .V_PIXELS(120), .COLOUR_RESET(16'h00FF)) dut (
    .clk_i(clk), .reset_i(reset),
    .cpuReq_i(cpuReq), .cpuWe_i(cpuWe), .cpuX_i(cpuX), .cpuY_i(cpuY), .cpuWdata_i(cpuWdata),
    .cpuAck_o(cpuAck), .cpuRdata_o(cpuRdata), .cpuRvalid_o(cpuRvalid),
    .fillStart_i(fillStart), .fillX0_i(fillX0), .fillX1_i(fillX1),
    .fillY0_i(fillY0), .fillY1_i(fillY1), .fillValue_i(fillValue),
    .fillBusy_o(fillBusy), .fillDone_o(fillDone),
    .colourWe_i(colourWe), .colourIn_i(colourIn), .configColours_o(configColours),
    .fbAddr_o(fbAddr), .fbWdata_o(fbWdata), .fbWe_o(fbWe), .fbRdata_i(fbRdata)
  );

  always #5 clk = ~clk;

  // Frame buffer model: synchronous write, registered read (data valid one cycle after address).
  always @(posedge clk) begin
    if (pokeEn) fbMem[pokeAddr] <= 1'b1;
    else if (fbWe) fbMem[fbAddr] <= fbWdata;
    fbRdata <= fbMem[fbAddr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpuReq = 0; cpuWe = 0; cpuX = '0; cpuY = '0; cpuWdata = 0;
    fillStart = 0; fillValue = 0; fillX0 = '0; fillX1 = '0; fillY0 = '0; fillY1 = '0;
    colourWe = 0; colourIn = '0;
  endtask

  // Starts a fill in cycle 0 and logs FB writes, FILL_DONE pulses and busy over maxCyc cycles.
  task automatic run_fill(input logic [7:0] x0, input logic [7:0] x1, input logic [6:0] y0,
                          input logic [6:0] y1, input logic v, input int preStart,
                          input int preLen, input int maxCyc);
    wrAddr.delete(); wrCycle.delete(); doneCycles.delete(); sawBusy = 0;
    fillX0 = x0; fillX1 = x1; fillY0 = y0; fillY1 = y1; fillValue = v; fillStart = 1;
    for (int c = 1; c <= maxCyc; c++) begin
      tick();
      fillStart = 0;
      if (fbWe) begin wrAddr.push_back(fbAddr); wrCycle.push_back(c); end
      if (fillDone) doneCycles.push_back(c);
      if (fillBusy) sawBusy = 1;
      if (c >= preStart && c < preStart + preLen) begin
        cpuReq = 1; cpuWe = 1; cpuX = 8'(100 + c - preStart); cpuY = 7'd50; cpuWdata = 1;
      end else begin
        cpuReq = 0; cpuWe = 0;
      end
    end
  endtask

  task automatic check_fill_log(input string name, input logic [14:0] expA[$],
                                input int firstCyc, input int expDone);
    int doneAt;
    nChecks++;
    if (wrAddr.size() !== expA.size()) begin
      nFails++;
      $display("[TB] FAIL %s write count: got %0d expected %0d", name, wrAddr.size(), expA.size());
    end
    for (int i = 0; i < expA.size(); i++) begin
      logic [14:0] a;
      int cyc;
      a   = (i < wrAddr.size()) ? wrAddr[i] : 15'h7FFF;
      cyc = (i < wrCycle.size()) ? wrCycle[i] : -1;
      nChecks++;
      if (a !== expA[i] || cyc !== firstCyc + i) begin
        nFails++;
        $display("[TB] FAIL %s write %0d: got addr %h cycle %0d expected addr %h cycle %0d",
                 name, i, a, cyc, expA[i], firstCyc + i);
      end
    end
    doneAt = (doneCycles.size() > 0) ? doneCycles[0] : -1;
    nChecks++;
    if (doneCycles.size() !== 1 || doneAt !== expDone) begin
      nFails++;
      $display("[TB] FAIL %s fill_done: got %0d pulses first at %0d expected 1 pulse at %0d",
               name, doneCycles.size(), doneAt, expDone);
    end
  endtask

  task automatic test_reset();
    int weSeen;
    idle_inputs();
    reset = 1;
    tick(); tick();
    nChecks++;
    if ({fbAddr, fbWdata, fbWe, cpuAck, cpuRdata, cpuRvalid, fillBusy, fillDone} !== 23'd0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs: got addr %h wd %b we %b ack %b rd %b rv %b busy %b done %b expected all 0",
               fbAddr, fbWdata, fbWe, cpuAck, cpuRdata, cpuRvalid, fillBusy, fillDone);
    end
    nChecks++;
    if (configColours !== 16'h00FF) begin
      nFails++;
      $display("[TB] FAIL reset_colours: got %h expected 00ff", configColours);
    end
    reset = 0;
    weSeen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fbWe) weSeen++;
    end
    nChecks++;
    if (weSeen !== 0) begin
      nFails++;
      $display("[TB] FAIL idle_fb_we: got %0d write cycles expected 0", weSeen);
    end
  endtask

  task automatic test_cpu_write_read();
    cpuReq = 1; cpuWe = 1; cpuX = 8'd5; cpuY = 7'd3; cpuWdata = 1;
    tick();
    cpuReq = 0; cpuWe = 0;
    nChecks++;
    if (fbAddr !== 15'h0305 || fbWe !== 1'b1 || cpuAck !== 1'b1 || fbWdata !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL cpu_write_issue: got addr %h we %b ack %b wd %b expected 0305 1 1 1",
               fbAddr, fbWe, cpuAck, fbWdata);
    end
    tick();
    cpuReq = 1; cpuWe = 0; cpuX = 8'd5; cpuY = 7'd3;
    tick();
    cpuReq = 0;
    nChecks++;
    if (fbAddr !== 15'h0305 || fbWe !== 1'b0 || cpuAck !== 1'b1 || cpuRvalid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL cpu_read_issue: got addr %h we %b ack %b rv %b expected 0305 0 1 0",
               fbAddr, fbWe, cpuAck, cpuRvalid);
    end
    tick();
    nChecks++;
    if (cpuRvalid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL cpu_read_early: got rvalid %b expected 0", cpuRvalid);
    end
    tick();
    nChecks++;
    if (cpuRvalid !== 1'b1 || cpuRdata !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL cpu_read_result: got rv %b rd %b expected 1 1", cpuRvalid, cpuRdata);
    end
    tick();
    nChecks++;
    if (cpuRvalid !== 1'b0 || cpuRdata !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL cpu_read_hold: got rv %b rd %b expected 0 1", cpuRvalid, cpuRdata);
    end
  endtask

  task automatic test_back_to_back();
    logic expRd[3];
    cpuReq = 1; cpuWe = 1; cpuX = 8'd6; cpuY = 7'd3; cpuWdata = 0;
    tick();
    cpuReq = 0; cpuWe = 0;
    pokeAddr = {7'd3, 8'd200}; pokeEn = 1;
    tick();
    pokeEn = 0;
    expRd[0] = 0; expRd[1] = 1; expRd[2] = 0;
    cpuReq = 1; cpuWe = 0; cpuX = 8'd6;   cpuY = 7'd3; tick();
    cpuX = 8'd5; tick();
    cpuX = 8'd200; tick();
    cpuReq = 0;
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if (cpuRvalid !== 1'b1 || cpuRdata !== expRd[i]) begin
        nFails++;
        $display("[TB] FAIL b2b_read %0d: got rv %b rd %b expected 1 %b", i, cpuRvalid, cpuRdata, expRd[i]);
      end
      tick();
    end
    nChecks++;
    if (cpuRvalid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL b2b_read_end: got rvalid %b expected 0", cpuRvalid);
    end
  endtask

  task automatic test_fill_basic();
    logic [14:0] expA[$];
    expA = '{15'd0, 15'd1, 15'd2, 15'd3, 15'd256, 15'd257, 15'd258, 15'd259};
    run_fill(8'd0, 8'd3, 7'd0, 7'd1, 1'b1, 0, 0, 16);
    check_fill_log("fill_basic", expA, 2, 10);
  endtask

  task automatic test_preempt();
    logic [14:0] expA[$];
    expA = '{15'd0, 15'd1, 15'd2, 15'h3264, 15'h3265, 15'd3, 15'd256, 15'd257, 15'd258, 15'd259};
    run_fill(8'd0, 8'd3, 7'd0, 7'd1, 1'b1, 4, 2, 18);
    check_fill_log("fill_preempt", expA, 2, 12);
  endtask

  task automatic test_clip_empty();
    logic [14:0] expA[$];
    expA = '{15'h779E, 15'h779F};
    run_fill(8'd158, 8'd200, 7'd119, 7'd127, 1'b1, 0, 0, 10);
    check_fill_log("fill_clip", expA, 2, 4);
    expA = '{};
    run_fill(8'd10, 8'd5, 7'd0, 7'd0, 1'b1, 0, 0, 8);
    check_fill_log("fill_empty", expA, 0, 2);
    nChecks++;
    if (sawBusy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL fill_empty_busy: got busy %b expected 0", sawBusy);
    end
    cpuReq = 1; cpuWe = 1; cpuX = 8'd160; cpuY = 7'd3; cpuWdata = 1;
    tick();
    cpuReq = 0; cpuWe = 0;
    nChecks++;
    if (cpuAck !== 1'b1 || fbWe !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL cpu_write_oor: got ack %b we %b expected 1 0", cpuAck, fbWe);
    end
  endtask

  task automatic test_reset_mid_fill();
    int events;
    colourWe = 1; colourIn = 16'h1234;
    tick();
    colourWe = 0;
    fillX0 = 8'd0; fillX1 = 8'd159; fillY0 = 7'd0; fillY1 = 7'd119; fillValue = 0; fillStart = 1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      fillStart = 0;
      if (c == 3) begin
        fillX0 = 8'd150; fillX1 = 8'd150; fillY0 = 7'd100; fillY1 = 7'd100; fillStart = 1;
      end
    end
    nChecks++;
    if (fbWe !== 1'b1 || fbAddr !== 15'd18 || fillBusy !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL clear_progress: got we %b addr %h busy %b expected 1 0012 1", fbWe, fbAddr, fillBusy);
    end
    cpuReq = 1; cpuWe = 0; cpuX = 8'd5; cpuY = 7'd3;
    tick();
    cpuReq = 0; reset = 1;
    tick();
    nChecks++;
    if (fbWe !== 1'b0 || fillBusy !== 1'b0 || cpuAck !== 1'b0 || configColours !== 16'h00FF) begin
      nFails++;
      $display("[TB] FAIL reset_mid_fill: got we %b busy %b ack %b col %h expected 0 0 0 00ff",
               fbWe, fillBusy, cpuAck, configColours);
    end
    reset = 0;
    events = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (fillDone || cpuRvalid || fbWe || fillBusy) events++;
    end
    nChecks++;
    if (events !== 0) begin
      nFails++;
      $display("[TB] FAIL post_reset_quiet: got %0d active cycles expected 0", events);
    end
  endtask

  task automatic test_colour();
    colourWe = 1; colourIn = 16'hE01C;
    cpuReq = 1; cpuWe = 1; cpuX = 8'd7; cpuY = 7'd7; cpuWdata = 1;
    nChecks++;
    if (configColours !== 16'h00FF) begin
      nFails++;
      $display("[TB] FAIL colour_before: got %h expected 00ff", configColours);
    end
    tick();
    colourWe = 0; colourIn = '0; cpuReq = 0; cpuWe = 0;
    nChecks++;
    if (configColours !== 16'hE01C) begin
      nFails++;
      $display("[TB] FAIL colour_load: got %h expected e01c", configColours);
    end
    tick();
    nChecks++;
    if (configColours !== 16'hE01C) begin
      nFails++;
      $display("[TB] FAIL colour_hold: got %h expected e01c", configColours);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write_read();
    test_back_to_back();
    test_fill_basic();
    test_preempt();
    test_clip_empty();
    test_reset_mid_fill();
    test_colour();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
